// File: rtl/modn_counter_pkg.sv
// Shared constants and helpers for the modulo-N up/down counter family.
package modn_counter_pkg;

   localparam int unsigned WIDTH_MIN = 1;
   localparam int unsigned WIDTH_MAX = 16;

   // Number of bits needed to hold values 0..value-1.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      int unsigned span;
      result = 0;
      span   = 1;
      while (span < value) begin
         span   = span << 1;
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/modn_next_state.sv
// Combinational next-count and wrap-event logic for modn_updown_counter.
// MODN_COUNTER_SATURATE_EN: hold at the boundary instead of wrapping.
module modn_next_state
   import modn_counter_pkg::*;
#(
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned MODULUS = 10
) (
   input  logic [WIDTH-1:0] q,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] next_q,
   output logic             at_term,
   output logic             wrap_event
);

   localparam int unsigned EW = WIDTH + 1;
   localparam logic [EW-1:0] MAX_E = EW'(MODULUS - 1);

`ifdef MODN_COUNTER_SATURATE_EN
   localparam bit SATURATE = 1'b1;
`else
   localparam bit SATURATE = 1'b0;
`endif

   logic [EW-1:0] q_e;
   logic [EW-1:0] d_e;
   logic [EW-1:0] step_e;

   // Extended-width arithmetic keeps MODULUS = 2**WIDTH representable.
   always_comb begin
      q_e        = {1'b0, q};
      d_e        = {1'b0, d};
      at_term    = up ? (q_e == MAX_E) : (q_e == '0);
      step_e     = q_e;
      next_q     = q;
      wrap_event = 1'b0;

      if (up) begin
         step_e = at_term ? '0 : q_e + EW'(1);
      end else begin
         step_e = at_term ? MAX_E : q_e - EW'(1);
      end
      if (SATURATE && at_term) begin
         step_e = q_e;
      end

      if (load) begin
         next_q = (d_e > MAX_E) ? WIDTH'(MAX_E) : d;
      end else if (en) begin
         next_q     = WIDTH'(step_e);
         wrap_event = at_term;
      end
   end

endmodule

// File: rtl/modn_updown_counter.sv
// Parametrised modulo-N up/down counter with load, cascadable tc and sticky wrap flag.
// MODN_COUNTER_SATURATE_EN: saturate at the boundary instead of wrapping.
module modn_updown_counter
   import modn_counter_pkg::*;
#(
   parameter int unsigned WIDTH     = 4,
   parameter int unsigned MODULUS   = 10,
   parameter int unsigned RESET_VAL = 0
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   input  logic             wrap_ack,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrapped
);

   if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
      $error("modn_updown_counter: WIDTH out of range");
   end
   if (MODULUS < 2 || clog2(MODULUS) > WIDTH) begin : g_bad_modulus
      $error("modn_updown_counter: MODULUS out of range for WIDTH");
   end
   if (RESET_VAL >= MODULUS) begin : g_bad_reset_val
      $error("modn_updown_counter: RESET_VAL must be below MODULUS");
   end

   localparam logic [WIDTH-1:0] RESET_Q = WIDTH'(RESET_VAL);

   logic [WIDTH-1:0] next_q;
   logic             at_term;
   logic             wrap_event;

   modn_next_state #(
      .WIDTH   (WIDTH),
      .MODULUS (MODULUS)
   ) u_next (
      .q          (q),
      .en         (en),
      .up         (up),
      .load       (load),
      .d          (d),
      .next_q     (next_q),
      .at_term    (at_term),
      .wrap_event (wrap_event)
   );

   // A wrap on the same edge as wrap_ack keeps the flag set.
   always_ff @(posedge clk) begin
      if (clr) begin
         q       <= RESET_Q;
         wrapped <= 1'b0;
      end else begin
         q <= next_q;
         if (wrap_event) begin
            wrapped <= 1'b1;
         end else if (wrap_ack) begin
            wrapped <= 1'b0;
         end
      end
   end

   assign tc = en & at_term;

endmodule

// File: tb/tb_modn_updown_counter.sv
// Directed self-checking bench for modn_updown_counter (single digit and cascaded pair).
module tb_modn_updown_counter;

`ifdef MODN_COUNTER_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic       clk;
   logic       clr;
   logic       en;
   logic       up;
   logic       load;
   logic [3:0] d;
   logic       wrap_ack;
   logic [3:0] q;
   logic       tc;
   logic       wrapped;

   logic       c_clr;
   logic       c_one;
   logic       c_zero;
   logic [3:0] c_d;
   logic [3:0] lo_q;
   logic [3:0] hi_q;
   logic       lo_tc;
   logic       hi_tc;
   logic       lo_wrapped;
   logic       hi_wrapped;

   int n_checks;
   int n_fail;

   modn_updown_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) u_dut (
      .clk(clk), .clr(clr), .en(en), .up(up), .load(load), .d(d),
      .wrap_ack(wrap_ack), .q(q), .tc(tc), .wrapped(wrapped)
   );

   modn_updown_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) u_lo (
      .clk(clk), .clr(c_clr), .en(c_one), .up(c_one), .load(c_zero), .d(c_d),
      .wrap_ack(c_zero), .q(lo_q), .tc(lo_tc), .wrapped(lo_wrapped)
   );

   modn_updown_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) u_hi (
      .clk(clk), .clr(c_clr), .en(lo_tc), .up(c_one), .load(c_zero), .d(c_d),
      .wrap_ack(c_zero), .q(hi_q), .tc(hi_tc), .wrapped(hi_wrapped)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      n_checks = n_checks + 1;
      if (got !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      int unsigned exp;
      n_checks = 0;
      n_fail   = 0;
      clr = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; d = 4'd0; wrap_ack = 1'b0;
      c_clr = 1'b1; c_one = 1'b1; c_zero = 1'b0; c_d = 4'd0;

      // Reset state
      tick;
      check("rst_q", 32'(q), 0);
      check("rst_wrapped", 32'(wrapped), 0);
      check("rst_tc", 32'(tc), 0);

      // Count up through a wrap
      clr = 1'b0; en = 1'b1; up = 1'b1;
      for (int i = 0; i < 12; i++) begin
         #1;
         check("t1_tc", 32'(tc), SAT ? 32'(i >= 9) : 32'(i == 9));
         tick;
         check("t1_q", 32'(q), SAT ? ((i + 1 > 9) ? 9 : i + 1) : (i + 1) % 10);
         check("t1_wrapped", 32'(wrapped), 32'(i >= 9));
      end

      // Load 0 with ack to clear the flag, then count down
      en = 1'b0; load = 1'b1; d = 4'd0; wrap_ack = 1'b1;
      tick;
      check("t2_load_q", 32'(q), 0);
      check("t2_ack_wrapped", 32'(wrapped), 0);
      load = 1'b0; wrap_ack = 1'b0; en = 1'b1; up = 1'b0;
      #1;
      check("t2_tc_at0", 32'(tc), 1);
      tick;
      check("t2_q1", 32'(q), SAT ? 0 : 9);
      check("t2_wrapped", 32'(wrapped), 1);
      check("t2_tc_after", 32'(tc), SAT ? 1 : 0);
      tick;
      check("t2_q2", 32'(q), SAT ? 0 : 8);
      tick;
      check("t2_q3", 32'(q), SAT ? 0 : 7);

      // Load beats en; out-of-range load clamps; flag untouched
      load = 1'b1; en = 1'b1; up = 1'b1; d = 4'd5;
      tick;
      check("t3_load5", 32'(q), 5);
      check("t3_wrapped5", 32'(wrapped), 1);
      d = 4'd12;
      tick;
      check("t3_clamp", 32'(q), 9);
      check("t3_wrapped12", 32'(wrapped), 1);

      // clr beats load and en
      clr = 1'b1; load = 1'b1; d = 4'd3; en = 1'b1;
      tick;
      check("t4_clr_q", 32'(q), 0);
      check("t4_clr_wrapped", 32'(wrapped), 0);
      load = 1'b0; up = 1'b1;
      exp = 0;
      for (int k = 1; k <= 10; k++) begin
         clr = (k % 5 == 0);
         tick;
         exp = clr ? 0 : exp + 1;
         check("t4_q", 32'(q), exp);
      end
      clr = 1'b0;

      // wrap_ack coinciding with a wrap, then ack alone
      load = 1'b1; d = 4'd8; en = 1'b0;
      tick;
      check("t6_load8", 32'(q), 8);
      load = 1'b0; en = 1'b1;
      tick;
      check("t6_q9", 32'(q), 9);
      check("t6_tc9", 32'(tc), 1);
      check("t6_pre_wrapped", 32'(wrapped), 0);
      wrap_ack = 1'b1;
      tick;
      check("t6_wrap_q", 32'(q), SAT ? 9 : 0);
      check("t6_set_wins", 32'(wrapped), 1);
      check("t6_tc", 32'(tc), SAT ? 1 : 0);
      en = 1'b0;
      tick;
      check("t6_ack_clears", 32'(wrapped), 0);
      check("t6_hold_q", 32'(q), SAT ? 9 : 0);
      wrap_ack = 1'b0;

`ifndef MODN_COUNTER_SATURATE_EN
      // Two-digit cascade counting 00..99 then 00
      c_clr = 1'b0;
      check("t5_lo_start", 32'(lo_q), 0);
      check("t5_hi_start", 32'(hi_q), 0);
      for (int n = 0; n < 100; n++) begin
         #1;
         check("t5_hi_tc", 32'(hi_tc), 32'(n == 99));
         tick;
         check("t5_count", 32'(hi_q) * 10 + 32'(lo_q), (n + 1) % 100);
      end
      check("t5_lo_wrapped", 32'(lo_wrapped), 1);
      check("t5_hi_wrapped", 32'(hi_wrapped), 1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
